// File: rtl/register_file_mp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | register_file_mp                                                            |
// | Multi-port register file with write bypass, zero register and scoreboard.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           read,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] addr_r,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_r,
    output logic [NUM_READ-1:0]            busy_r,
    output logic                           data_r_valid,
    input  logic                           write,
    input  logic [ADDR_WIDTH-1:0]          addr_w,
    input  logic [DATA_WIDTH-1:0]          data_w,
    input  logic                           reserve,
    input  logic [ADDR_WIDTH-1:0]          addr_rsv,
    output logic [ADDR_WIDTH:0]            pend_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_nxt;
    logic                  wr_en;
    logic                  rsv_en;
    logic                  cnt_inc;
    logic                  cnt_dec;
    logic [DATA_WIDTH-1:0] nxt_data [NUM_READ];
    logic [NUM_READ-1:0]   nxt_busy;

    assign wr_en  = write   && !((ZERO_REG != 0) && (addr_w   == '0));
    assign rsv_en = reserve && !((ZERO_REG != 0) && (addr_rsv == '0));

    // A reserve on the address being written wins, so no decrement then.
    assign cnt_inc = rsv_en && !pending[addr_rsv];
    assign cnt_dec = wr_en && pending[addr_w] && !(rsv_en && (addr_rsv == addr_w));

    always_comb begin
        pending_nxt = pending;
        if (wr_en) begin
            pending_nxt[addr_w] = 1'b0;
        end
        if (rsv_en) begin
            pending_nxt[addr_rsv] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic                  zero_hit;
        logic                  byp_hit;

        assign ra       = addr_r[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);
        assign byp_hit  = (BYPASS != 0) && wr_en && (addr_w == ra);

        assign nxt_data[k] = zero_hit ? '0 : (byp_hit ? data_w : regs[ra]);
        assign nxt_busy[k] = zero_hit ? 1'b0 : (byp_hit ? 1'b0 : pending[ra]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending      <= '0;
            pend_cnt     <= '0;
            data_r       <= '0;
            busy_r       <= '0;
            data_r_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[addr_w] <= data_w;
            end
            pending      <= pending_nxt;
            pend_cnt     <= pend_cnt + {{ADDR_WIDTH{1'b0}}, cnt_inc}
                                     - {{ADDR_WIDTH{1'b0}}, cnt_dec};
            data_r_valid <= read;
            if (read) begin
                for (int k = 0; k < NUM_READ; k++) begin
                    data_r[k*DATA_WIDTH +: DATA_WIDTH] <= nxt_data[k];
                end
                busy_r <= nxt_busy;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_register_file_mp                                                         |
// | Bench for register_file_mp: two builds (bypass+zero, plain) vs a model.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [9:0]  addr_r;
    logic        write;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        reserve;
    logic [4:0]  addr_rsv;

    logic [63:0] data_a, data_b;
    logic [1:0]  busy_a, busy_b;
    logic        valid_a, valid_b;
    logic [5:0]  cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    // Instance 0: BYPASS=1, ZERO_REG=1. Instance 1: BYPASS=0, ZERO_REG=0.
    logic [31:0] mreg  [2][32];
    bit          mpend [2][32];
    logic [63:0] exp_d [2];
    logic [1:0]  exp_b [2];
    logic        exp_v [2];

    always #5 clk = ~clk;

    register_file_mp dut_a (
        .clk(clk), .rst(rst), .read(read), .addr_r(addr_r), .data_r(data_a),
        .busy_r(busy_a), .data_r_valid(valid_a), .write(write), .addr_w(addr_w),
        .data_w(data_w), .reserve(reserve), .addr_rsv(addr_rsv), .pend_cnt(cnt_a)
    );

    register_file_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .read(read), .addr_r(addr_r), .data_r(data_b),
        .busy_r(busy_b), .data_r_valid(valid_b), .write(write), .addr_w(addr_w),
        .data_w(data_w), .reserve(reserve), .addr_rsv(addr_rsv), .pend_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) begin
                mreg[m][i]  = '0;
                mpend[m][i] = 1'b0;
            end
            exp_d[m] = '0;
            exp_b[m] = '0;
            exp_v[m] = 1'b0;
        end
    endtask

    function automatic int model_cnt(input int m);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mpend[m][i]);
        return n;
    endfunction

    // Apply one clock edge of the current inputs to the reference model.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit zr  = (m == 0);
            bit byp = (m == 0);
            bit wr_ok  = write   && !(zr && addr_w == 0);
            bit rsv_ok = reserve && !(zr && addr_rsv == 0);
            exp_v[m] = read;
            if (read) begin
                for (int k = 0; k < 2; k++) begin
                    int a = int'(addr_r[k*5 +: 5]);
                    if (zr && a == 0) begin
                        exp_d[m][k*32 +: 32] = 32'h0;
                        exp_b[m][k] = 1'b0;
                    end else if (byp && wr_ok && int'(addr_w) == a) begin
                        exp_d[m][k*32 +: 32] = data_w;
                        exp_b[m][k] = 1'b0;
                    end else begin
                        exp_d[m][k*32 +: 32] = mreg[m][a];
                        exp_b[m][k] = mpend[m][a];
                    end
                end
            end
            if (wr_ok) begin
                mreg[m][addr_w]  = data_w;
                mpend[m][addr_w] = 1'b0;
            end
            if (rsv_ok) mpend[m][addr_rsv] = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("data_a",  data_a,  exp_d[0]);
        chk("busy_a",  64'(busy_a),  64'(exp_b[0]));
        chk("valid_a", 64'(valid_a), 64'(exp_v[0]));
        chk("cnt_a",   64'(cnt_a),   64'(model_cnt(0)));
        chk("data_b",  data_b,  exp_d[1]);
        chk("busy_b",  64'(busy_b),  64'(exp_b[1]));
        chk("valid_b", 64'(valid_b), 64'(exp_v[1]));
        chk("cnt_b",   64'(cnt_b),   64'(model_cnt(1)));
    endtask

    task automatic do_cycle(input logic rd, input logic [4:0] a0, input logic [4:0] a1,
                            input logic wr, input logic [4:0] aw, input logic [31:0] dw,
                            input logic rs, input logic [4:0] ars);
        read = rd; addr_r = {a1, a0};
        write = wr; addr_w = aw; data_w = dw;
        reserve = rs; addr_rsv = ars;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_data_a"}, data_a, 64'h0);
        chk({tag, "_busy_a"}, 64'(busy_a), 64'h0);
        chk({tag, "_valid_a"}, 64'(valid_a), 64'h0);
        chk({tag, "_cnt_a"}, 64'(cnt_a), 64'h0);
        chk({tag, "_data_b"}, data_b, 64'h0);
        chk({tag, "_valid_b"}, 64'(valid_b), 64'h0);
        chk({tag, "_cnt_b"}, 64'(cnt_b), 64'h0);
    endtask

    initial begin
        rst = 1'b1; read = 0; addr_r = '0; write = 0; addr_w = '0;
        data_w = '0; reserve = 0; addr_rsv = '0;
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Reset then read
        do_cycle(1, 5'd0, 5'd31, 0, 0, 0, 0, 0);
        chk("first_valid", 64'(valid_a), 64'h1);

        // Write / read and zero register
        do_cycle(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
        do_cycle(1, 5'd5, 5'd6, 0, 0, 0, 0, 0);
        chk("r5_read", 64'(data_a[31:0]), 64'hDEADBEEF);
        do_cycle(0, 0, 0, 1, 5'd0, 32'h1, 0, 0);
        do_cycle(1, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        chk("r0_zero", 64'(data_a[31:0]), 64'h0);

        // Bypass on one build, pre-write value on the other
        do_cycle(0, 0, 0, 1, 5'd7, 32'h11, 0, 0);
        do_cycle(1, 5'd7, 5'd7, 1, 5'd7, 32'h22, 0, 0);
        chk("byp_on",  64'(data_a[31:0]), 64'h22);
        chk("byp_off", 64'(data_b[31:0]), 64'h11);
        do_cycle(1, 5'd7, 5'd7, 0, 0, 0, 0, 0);
        chk("after_byp", 64'(data_b[63:32]), 64'h22);

        // Scoreboard
        do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd3);
        do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd4);
        chk("cnt2", 64'(cnt_a), 64'd2);
        do_cycle(1, 5'd3, 5'd4, 0, 0, 0, 0, 0);
        chk("busy34", 64'(busy_a), 64'h3);
        do_cycle(0, 0, 0, 1, 5'd3, 32'h33, 0, 0);
        do_cycle(0, 0, 0, 1, 5'd4, 32'h44, 1, 5'd4);
        chk("rsv_wins", 64'(cnt_a), 64'd1);
        do_cycle(1, 5'd4, 5'd3, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 5'd4, 32'h45, 1, 5'd9);
        chk("set_clr_net0", 64'(cnt_a), 64'd1);
        do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd0);
        chk("rsv_r0", 64'(cnt_a), 64'd1);
        do_cycle(1, 5'd9, 5'd0, 0, 0, 0, 0, 0);

        // Async reset pulsed between edges, right after a read
        do_cycle(1, 5'd5, 5'd9, 0, 0, 0, 1, 5'd12);
        read = 0; write = 0; reserve = 0;
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_rst");
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        do_cycle(1, 5'd5, 5'd7, 0, 0, 0, 0, 0);
        chk("post_rst_r5", 64'(data_b[31:0]), 64'h0);

        // Randomized traffic, mostly on a narrow address window to force collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] r0, r1, aw, ar;
            bit narrow = ($urandom_range(0, 3) != 0);
            r0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            r1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            aw = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ar = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            do_cycle(1'($urandom), r0, r1, 1'($urandom), aw, $urandom,
                     1'($urandom), ar);
        end

        // Fill every register as pending to reach the counter ceiling
        for (int i = 0; i < 32; i++) begin
            do_cycle(0, 0, 0, 0, 0, 0, 1, 5'(i));
        end
        chk("cnt_max_a", 64'(cnt_a), 64'd31);
        chk("cnt_max_b", 64'(cnt_b), 64'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
